// File: rtl/sr_ff_monitor.sv
// sr_ff_monitor: sits beside an SR flip-flop and checks it.
// It keeps its own model of the flip-flop, delays the model by LATENCY
// enabled edges, and compares that delayed value with the DUT's Q and Qn.
// It also counts set, reset and invalid (S=R=1) input events.
//
// state   | meaning
// --------+----------------------------------------------------------
// WARMUP  | pipe not yet filled since reset; no compare
// CHECK   | pipe head known; compare active
// UNKNOWN | pipe head unknown (after S=R=1 or from reset); no compare
// FAULT   | first error seen with STOP_ON_ERR=1; compare off until reset
module sr_ff_monitor #(
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 8,
  parameter int CYC_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_n,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CYC_W-1:0] cyc_cnt,
  output logic [CYC_W-1:0] first_err
);

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_CHECK   = 2'd1,
    ST_UNKNOWN = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [1:0]       WARM_LOAD = 2'(LATENCY - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_warm_tmr;
  logic               r_model_q;
  logic               r_model_k;
  logic               w_model_q;
  logic               w_model_k;
  logic [LATENCY-1:0] r_pipe_q;
  logic [LATENCY-1:0] r_pipe_k;
  logic [LATENCY-1:0] r_pipe_v;
  logic               w_head_q;
  logic               w_head_k;
  logic               w_head_v;
  logic               w_exp_valid;
  logic               w_fail;
  logic               r_mismatch;
  logic               r_err_sticky;
  logic [CNT_W-1:0]   r_set_cnt;
  logic [CNT_W-1:0]   r_rst_cnt;
  logic [CNT_W-1:0]   r_inv_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CYC_W-1:0]   r_cyc_cnt;
  logic [CYC_W-1:0]   r_first_err;

  // Reference flip-flop: next model value from the sampled S/R pair.
  always_comb begin
    w_model_q = r_model_q;
    w_model_k = r_model_k;
    case ({s, r})
      2'b10:   begin w_model_q = 1'b1; w_model_k = 1'b1; end
      2'b01:   begin w_model_q = 1'b0; w_model_k = 1'b1; end
      2'b11:   w_model_k = 1'b0;
      default: ;
    endcase
  end

  // Model register; only advances on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_model_q <= 1'b0;
      r_model_k <= 1'b0;
    end else if (en) begin
      r_model_q <= w_model_q;
      r_model_k <= w_model_k;
    end
  end

  // Delay pipe: entry 0 is newest, entry LATENCY-1 is the head under compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_q <= '0;
      r_pipe_k <= '0;
      r_pipe_v <= '0;
    end else if (en) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        r_pipe_q[i] <= r_pipe_q[i-1];
        r_pipe_k[i] <= r_pipe_k[i-1];
        r_pipe_v[i] <= r_pipe_v[i-1];
      end
      r_pipe_q[0] <= w_model_q;
      r_pipe_k[0] <= w_model_k;
      r_pipe_v[0] <= 1'b1;
    end
  end

  // Head decode and compare.
  always_comb begin
    w_head_q    = r_pipe_q[LATENCY-1];
    w_head_k    = r_pipe_k[LATENCY-1];
    w_head_v    = r_pipe_v[LATENCY-1];
    w_exp_valid = w_head_v & w_head_k & (r_state != ST_FAULT) & (r_state != ST_WARMUP);
    w_fail      = en & w_exp_valid & ((q != w_head_q) | (q_n == q));
  end

  // Warm-up down-counter: terminal count marks the pipe as filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm_tmr <= WARM_LOAD;
    end else if (en && (r_state == ST_WARMUP) && (r_warm_tmr != 2'd0)) begin
      r_warm_tmr <= r_warm_tmr - 2'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WARMUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A fail can only occur in CHECK or UNKNOWN (head known
  // but the UNKNOWN->CHECK move not yet taken); both stop into FAULT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WARMUP: begin
        if (en && (r_warm_tmr == 2'd0)) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_fail && STOP_ON_ERR) w_state_nxt = ST_FAULT;
        else if (en && !w_head_k)  w_state_nxt = ST_UNKNOWN;
      end
      ST_UNKNOWN: begin
        if (w_fail && STOP_ON_ERR) w_state_nxt = ST_FAULT;
        else if (en && w_head_k)   w_state_nxt = ST_CHECK;
      end
      ST_FAULT: ;
      default: w_state_nxt = ST_WARMUP;
    endcase
  end

  // Error reporting: one-cycle pulse, sticky flag, saturating count, timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
    end else begin
      r_mismatch <= w_fail;
      if (w_fail) begin
        r_err_sticky <= 1'b1;
        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_ONE;
        if (!r_err_sticky) r_first_err <= r_cyc_cnt;
      end
    end
  end

  // Event counters (saturating) and enabled-edge counter (wrapping).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_cnt <= '0;
      r_rst_cnt <= '0;
      r_inv_cnt <= '0;
      r_cyc_cnt <= '0;
    end else if (en) begin
      r_cyc_cnt <= r_cyc_cnt + CYC_ONE;
      if (s && !r && (r_set_cnt != CNT_MAX)) r_set_cnt <= r_set_cnt + CNT_ONE;
      if (!s && r && (r_rst_cnt != CNT_MAX)) r_rst_cnt <= r_rst_cnt + CNT_ONE;
      if (s && r && (r_inv_cnt != CNT_MAX))  r_inv_cnt <= r_inv_cnt + CNT_ONE;
    end
  end

  assign exp_q      = w_head_q;
  assign exp_valid  = w_exp_valid;
  assign mismatch   = r_mismatch;
  assign err_sticky = r_err_sticky;
  assign set_cnt    = r_set_cnt;
  assign rst_cnt    = r_rst_cnt;
  assign inv_cnt    = r_inv_cnt;
  assign err_cnt    = r_err_cnt;
  assign cyc_cnt    = r_cyc_cnt;
  assign first_err  = r_first_err;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Bench for sr_ff_monitor: three instances with different LATENCY / CNT_W /
// CYC_W / STOP_ON_ERR share the S/R/en/reset stimulus; each has its own Q/Qn.
// A history-based model predicts every output after every cycle.
module tb_sr_ff_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, s, r;
  logic q [3];
  logic q_n [3];

  logic eq [3];
  logic ev [3];
  logic mm [3];
  logic es [3];
  logic [7:0]  a_set, a_rst, a_inv, a_err;
  logic [1:0]  b_set, b_rst, b_inv, b_err;
  logic [3:0]  c_set, c_rst, c_inv, c_err;
  logic [15:0] a_cyc, a_fe, b_cyc, b_fe;
  logic [7:0]  c_cyc, c_fe;

  sr_ff_monitor #(.LATENCY(1), .CNT_W(8), .CYC_W(16), .STOP_ON_ERR(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .q(q[0]), .q_n(q_n[0]),
    .exp_q(eq[0]), .exp_valid(ev[0]), .mismatch(mm[0]), .err_sticky(es[0]),
    .set_cnt(a_set), .rst_cnt(a_rst), .inv_cnt(a_inv), .err_cnt(a_err),
    .cyc_cnt(a_cyc), .first_err(a_fe));

  sr_ff_monitor #(.LATENCY(4), .CNT_W(2), .CYC_W(16), .STOP_ON_ERR(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .q(q[1]), .q_n(q_n[1]),
    .exp_q(eq[1]), .exp_valid(ev[1]), .mismatch(mm[1]), .err_sticky(es[1]),
    .set_cnt(b_set), .rst_cnt(b_rst), .inv_cnt(b_inv), .err_cnt(b_err),
    .cyc_cnt(b_cyc), .first_err(b_fe));

  sr_ff_monitor #(.LATENCY(2), .CNT_W(4), .CYC_W(8), .STOP_ON_ERR(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .q(q[2]), .q_n(q_n[2]),
    .exp_q(eq[2]), .exp_valid(ev[2]), .mismatch(mm[2]), .err_sticky(es[2]),
    .set_cnt(c_set), .rst_cnt(c_rst), .inv_cnt(c_inv), .err_cnt(c_err),
    .cyc_cnt(c_cyc), .first_err(c_fe));

  // Per-instance parameters as the model sees them.
  int L  [3] = '{1, 4, 2};
  int CW [3] = '{8, 2, 4};
  int YW [3] = '{16, 16, 8};
  bit STP[3] = '{1'b0, 1'b0, 1'b1};

  // Model: history of flip-flop values, indexed by enabled edge number.
  bit hq [3][4096];
  bit hk [3][4096];
  int n_edge [3];
  int m_set [3], m_rst [3], m_inv [3], m_err [3], m_fe [3];
  bit m_sticky [3], m_fault [3], m_mis [3], m_q [3], m_k [3];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  function automatic int wrap(input int v, input int w);
    return v & ((1 << w) - 1);
  endfunction

  function automatic bit head_q(input int i);
    return (n_edge[i] >= L[i]) ? hq[i][(n_edge[i] - L[i]) & 4095] : 1'b0;
  endfunction

  function automatic bit head_valid(input int i);
    return (n_edge[i] >= L[i]) && !m_fault[i] && hk[i][(n_edge[i] - L[i]) & 4095];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      n_edge[i] = 0; m_set[i] = 0; m_rst[i] = 0; m_inv[i] = 0; m_err[i] = 0;
      m_fe[i] = 0; m_sticky[i] = 0; m_fault[i] = 0; m_mis[i] = 0;
      m_q[i] = 0; m_k[i] = 0;
    end
  endfunction

  function automatic void m_step(input int i);
    bit fail;
    fail = head_valid(i) && ((q[i] != head_q(i)) || (q_n[i] == q[i]));
    if (s && !r) begin m_q[i] = 1; m_k[i] = 1; m_set[i] = sat_inc(m_set[i], CW[i]); end
    if (!s && r) begin m_q[i] = 0; m_k[i] = 1; m_rst[i] = sat_inc(m_rst[i], CW[i]); end
    if (s && r)  begin m_k[i] = 0; m_inv[i] = sat_inc(m_inv[i], CW[i]); end
    hq[i][n_edge[i] & 4095] = m_q[i];
    hk[i][n_edge[i] & 4095] = m_k[i];
    if (fail) begin
      m_err[i] = sat_inc(m_err[i], CW[i]);
      if (!m_sticky[i]) m_fe[i] = wrap(n_edge[i], YW[i]);
      m_sticky[i] = 1;
      if (STP[i]) m_fault[i] = 1;
    end
    m_mis[i] = fail;
    n_edge[i]++;
  endfunction

  task automatic check_one(input int i, input logic [31:0] vset, input logic [31:0] vrst,
                           input logic [31:0] vinv, input logic [31:0] verr,
                           input logic [31:0] vcyc, input logic [31:0] vfe);
    string p;
    p = $sformatf("u%0d", i);
    chk({p, ".exp_q"}, 32'(eq[i]), 32'(head_q(i)));
    chk({p, ".exp_valid"}, 32'(ev[i]), 32'(head_valid(i)));
    chk({p, ".mismatch"}, 32'(mm[i]), 32'(m_mis[i]));
    chk({p, ".err_sticky"}, 32'(es[i]), 32'(m_sticky[i]));
    chk({p, ".set_cnt"}, vset, 32'(m_set[i]));
    chk({p, ".rst_cnt"}, vrst, 32'(m_rst[i]));
    chk({p, ".inv_cnt"}, vinv, 32'(m_inv[i]));
    chk({p, ".err_cnt"}, verr, 32'(m_err[i]));
    chk({p, ".cyc_cnt"}, vcyc, 32'(wrap(n_edge[i], YW[i])));
    chk({p, ".first_err"}, vfe, 32'(m_fe[i]));
  endtask

  task automatic check_all();
    check_one(0, 32'(a_set), 32'(a_rst), 32'(a_inv), 32'(a_err), 32'(a_cyc), 32'(a_fe));
    check_one(1, 32'(b_set), 32'(b_rst), 32'(b_inv), 32'(b_err), 32'(b_cyc), 32'(b_fe));
    check_one(2, 32'(c_set), 32'(c_rst), 32'(c_inv), 32'(c_err), 32'(c_cyc), 32'(c_fe));
  endtask

  // mode 0: correct DUT, 1: random Q/Qn, 2: Q stuck 0, 3: Qn equal to Q
  task automatic drive(input bit ve, input bit vs, input bit vr, input int mode);
    en = ve; s = vs; r = vr;
    for (int i = 0; i < 3; i++) begin
      case (mode)
        0:       begin q[i] = head_q(i); q_n[i] = ~head_q(i); end
        1:       begin q[i] = 1'($urandom); q_n[i] = 1'($urandom); end
        2:       begin q[i] = 1'b0; q_n[i] = 1'b1; end
        default: begin q[i] = head_q(i); q_n[i] = head_q(i); end
      endcase
    end
    for (int i = 0; i < 3; i++) begin
      if (ve) m_step(i);
      else m_mis[i] = 0;
    end
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic pulse_reset();
    en = 1'b0; s = 1'b0; r = 1'b0;
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s = 1'b0; r = 1'b0;
    for (int i = 0; i < 3; i++) begin q[i] = 1'b0; q_n[i] = 1'b1; end
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic set / hold / reset with a well-behaved flip-flop.
    drive(1, 1, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 1, 0); drive(1, 0, 0, 0);
    chk("t1_set", 32'(a_set), 1);
    chk("t1_rst", 32'(a_rst), 1);
    chk("t1_sticky", 32'(es[0]), 0);

    // Q stuck at 0; set applied at cycle 3 is caught at the cycle-4 compare.
    pulse_reset();
    drive(1, 0, 0, 2); drive(1, 0, 0, 2); drive(1, 0, 0, 2);
    drive(1, 1, 0, 2); drive(1, 0, 0, 2);
    chk("t2_mismatch", 32'(mm[0]), 1);
    chk("t2_err", 32'(a_err), 1);
    chk("t2_first", 32'(a_fe), 4);
    drive(1, 0, 0, 0);
    chk("t2_pulse_end", 32'(mm[0]), 0);

    // Invalid S=R=1 run: expectation unknown until the following 01 lands.
    pulse_reset();
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    chk("t3_ev_after_11", 32'(ev[0]), 0);
    drive(1, 1, 1, 1); drive(1, 1, 1, 1);
    drive(1, 0, 0, 1); drive(1, 0, 0, 1);
    drive(1, 0, 1, 1);
    chk("t3_ev_after_01", 32'(ev[0]), 1);
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    chk("t3_inv", 32'(a_inv), 3);
    chk("t3_err", 32'(a_err), 0);

    // Qn equal to Q while known: errors every compare, narrow counter saturates,
    // and the stop-on-error instance counts only the first.
    pulse_reset();
    drive(1, 1, 0, 0);
    for (int k = 0; k < 9; k++) drive(1, 0, 0, 3);
    chk("t4_err_a", 32'(a_err), 9);
    chk("t4_first_a", 32'(a_fe), 1);
    chk("t4_err_b_sat", 32'(b_err), 3);
    chk("t4_first_b", 32'(b_fe), 4);
    chk("t5_err_c", 32'(c_err), 1);
    chk("t5_first_c", 32'(c_fe), 2);
    for (int k = 0; k < 3; k++) drive(1, 1, 0, 3);
    chk("t5_err_c_frozen", 32'(c_err), 1);
    chk("t5_set_c", 32'(c_set), 4);
    chk("t5_cyc_c", 32'(c_cyc), 13);

    // Enable low freezes everything.
    pulse_reset();
    drive(1, 1, 0, 0); drive(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) drive(0, 1, 0, 1);
    chk("t6_cyc_frozen", 32'(a_cyc), 2);
    chk("t6_set_frozen", 32'(a_set), 1);
    chk("t6_mis_low", 32'(mm[0]), 0);

    // Randomised run.
    pulse_reset();
    for (int k = 0; k < 1500; k++) begin
      int md;
      md = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 29) == 0) ? 3 : 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      drive(($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), md);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
